// File: rtl/fb_pkg.sv
// Frame buffer sequencer shared definitions: state encoding (also decoded by
// the debug UART), frame geometry and the default watchdog limit.
package fb_pkg;

  typedef enum logic [3:0] {
    FB_IDLE      = 4'd0,
    FB_ISSUE_CLR = 4'd1,
    FB_WAIT_CLR  = 4'd2,
    FB_ARM       = 4'd3,
    FB_ISSUE_WR  = 4'd4,
    FB_WAIT_WR   = 4'd5,
    FB_WAIT_GRAY = 4'd6,
    FB_ISSUE_RD  = 4'd7,
    FB_WAIT_RD   = 4'd8,
    FB_DRAIN     = 4'd9
  } fb_state_e;

  localparam int FB_STATE_W = 4;
  localparam int FB_N       = 480;
  localparam int FB_M       = 320;
  localparam int FB_BYTES   = 3 * FB_N * FB_M;

  localparam logic [23:0] FB_TIMEOUT_DEFAULT = 24'd500000;

  // States in which the memory owns the handshake and the watchdog runs.
  function automatic logic fb_is_timed(input fb_state_e s);
    case (s)
      FB_WAIT_CLR, FB_WAIT_WR, FB_WAIT_RD, FB_DRAIN: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // States that put a command on the memory pins.
  function automatic logic fb_is_issue(input fb_state_e s);
    case (s)
      FB_ISSUE_CLR, FB_ISSUE_WR, FB_ISSUE_RD: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Debug encoding of a state, as seen on state_dbg.
  function automatic logic [FB_STATE_W-1:0] fb_state_dbg(input fb_state_e s);
    return FB_STATE_W'(s);
  endfunction

endpackage

// File: rtl/fb_watchdog.sv
// Phase watchdog: counts cycles while enabled, load-clears on request and
// flags the terminal cycle. A limit of zero disables it entirely.
module fb_watchdog
  import fb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = FB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [23:0] count_q;
  logic [23:0] count_d;
  logic        limit_on_s;

  assign limit_on_s = (TIMEOUT_CYCLES != 24'd0);

  // Expiry is the last enabled cycle: count_q holds cycles already spent.
  assign expired_o = en_i && limit_on_s && (count_q == (TIMEOUT_CYCLES - 24'd1));

  // Next count: clear wins, then saturating increment while enabled.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 24'd0;
    end else if (en_i && (count_q != 24'hFFFFFF)) begin
      count_d = count_q + 24'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 24'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fb_seq_ctrl.sv
// RGB frame buffer sequencer: clear / capture / stream commands to the frame
// memory, paced by camera frame-start and grayscaler readiness, with a
// per-phase watchdog and abort draining.
// Build option FB_AUTO_CLEAR_EN: continuous mode re-clears memory before
// every frame instead of only once after start.
module fb_seq_ctrl
  import fb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = FB_TIMEOUT_DEFAULT,
  parameter int          FCNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              cam_frame_start,
  input  logic              gray_ready,
  input  logic              mem_done,
  output logic              mem_en,
  output logic              mem_rw,
  output logic              mem_clear,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count,
  output logic              err_timeout,
  output logic [3:0]        state_dbg
);

`ifdef FB_AUTO_CLEAR_EN
  localparam fb_state_e CONT_NEXT = FB_ISSUE_CLR;
`else
  localparam fb_state_e CONT_NEXT = FB_ARM;
`endif

  fb_state_e         state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_clear_q, mem_clear_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              err_q, err_d;

  logic              wd_en_s;
  logic              wd_clr_s;
  logic              wd_expired_s;

  assign wd_en_s = fb_is_timed(state_q);
  // Restart the count on every entry into a timed state, and hold it at
  // zero everywhere else.
  assign wd_clr_s = (state_d != state_q) || !wd_en_s;

  fb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr_s),
    .en_i      (wd_en_s),
    .expired_o (wd_expired_s)
  );

  // Next-state, status and registered memory-pin decode.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    fcnt_d       = fcnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      FB_IDLE: begin
        if (start) begin
          state_d = FB_ISSUE_CLR;
          err_d   = 1'b0;
        end else begin
          state_d = FB_IDLE;
        end
      end

      // A command already on the pins cannot be recalled, so abort drains.
      FB_ISSUE_CLR: state_d = abort ? FB_DRAIN : FB_WAIT_CLR;
      FB_ISSUE_WR:  state_d = abort ? FB_DRAIN : FB_WAIT_WR;
      FB_ISSUE_RD:  state_d = abort ? FB_DRAIN : FB_WAIT_RD;

      FB_WAIT_CLR: begin
        if (abort) begin
          state_d = mem_done ? FB_IDLE : FB_DRAIN;
        end else if (mem_done) begin
          state_d = FB_ARM;
        end else if (wd_expired_s) begin
          state_d = FB_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = FB_WAIT_CLR;
        end
      end

      FB_ARM: begin
        if (abort) begin
          state_d = FB_IDLE;
        end else if (cam_frame_start) begin
          state_d = FB_ISSUE_WR;
        end else begin
          state_d = FB_ARM;
        end
      end

      FB_WAIT_WR: begin
        if (abort) begin
          state_d = mem_done ? FB_IDLE : FB_DRAIN;
        end else if (mem_done) begin
          state_d = FB_WAIT_GRAY;
        end else if (wd_expired_s) begin
          state_d = FB_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = FB_WAIT_WR;
        end
      end

      FB_WAIT_GRAY: begin
        if (abort) begin
          state_d = FB_IDLE;
        end else if (gray_ready) begin
          state_d = FB_ISSUE_RD;
        end else begin
          state_d = FB_WAIT_GRAY;
        end
      end

      FB_WAIT_RD: begin
        if (abort) begin
          // Completed-but-aborted reads are not counted as frames.
          state_d = mem_done ? FB_IDLE : FB_DRAIN;
        end else if (mem_done) begin
          frame_done_d = 1'b1;
          fcnt_d       = fcnt_q + FCNT_W'(1);
          state_d      = continuous ? CONT_NEXT : FB_IDLE;
        end else if (wd_expired_s) begin
          state_d = FB_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = FB_WAIT_RD;
        end
      end

      FB_DRAIN: begin
        if (mem_done) begin
          state_d = FB_IDLE;
        end else if (wd_expired_s) begin
          state_d = FB_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = FB_DRAIN;
        end
      end

      default: state_d = FB_IDLE;
    endcase

    // Pins are decoded from the next state so they align with ISSUE_x.
    mem_en_d    = fb_is_issue(state_d);
    mem_rw_d    = (state_d == FB_ISSUE_WR);
    mem_clear_d = (state_d == FB_ISSUE_CLR);
    busy_d      = (state_d != FB_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FB_IDLE;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fcnt_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_clear_q  <= mem_clear_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      fcnt_q       <= fcnt_d;
      err_q        <= err_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_rw      = mem_rw_q;
  assign mem_clear   = mem_clear_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = fcnt_q;
  assign err_timeout = err_q;
  assign state_dbg   = fb_state_dbg(state_q);

endmodule

// File: tb/tb_fb_seq_ctrl.sv
// Self-checking bench for fb_seq_ctrl: expected memory commands and frame
// completions are queued as stimulus is driven and consumed by a monitor.
`timescale 1ns/1ps
module tb_fb_seq_ctrl;

  localparam int FCNT_W = 2;

`ifdef FB_AUTO_CLEAR_EN
  localparam int EXP_CLR_T2 = 3;
`else
  localparam int EXP_CLR_T2 = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic              abort = 1'b0;
  logic              cam_frame_start = 1'b0;
  logic              gray_ready = 1'b0;
  logic              mem_done = 1'b0;
  logic              mem_en, mem_rw, mem_clear, busy, frame_done, err_timeout;
  logic [FCNT_W-1:0] frame_count;
  logic [3:0]        state_dbg;

  int n_chk = 0;
  int n_err = 0;
  int n_en  = 0;
  int n_clr = 0;
  logic [1:0]        exp_cmd[$];   // {clear, rw}
  logic [FCNT_W-1:0] exp_frm[$];
  logic [FCNT_W-1:0] exp_fc = '0;

  fb_seq_ctrl #(.TIMEOUT_CYCLES(24'd16), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .abort(abort), .cam_frame_start(cam_frame_start), .gray_ready(gray_ready),
    .mem_done(mem_done), .mem_en(mem_en), .mem_rw(mem_rw), .mem_clear(mem_clear),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, state_dbg, s);
  endtask

  // Monitor: every command and frame completion must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        n_en++;
        if (mem_clear) n_clr++;
        if (exp_cmd.size() == 0) chk("cmd_unexpected", mem_en, 1'b0);
        else chk("cmd", {mem_clear, mem_rw}, exp_cmd.pop_front());
      end
      if (frame_done) begin
        if (exp_frm.size() == 0) chk("frame_unexpected", frame_done, 1'b0);
        else chk("frame_count_at_done", frame_count, exp_frm.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    cam_frame_start = 1'b0; gray_ready = 1'b0; mem_done = 1'b0;
    exp_cmd.delete(); exp_frm.delete(); exp_fc = '0;
    repeat (3) tick();
    chk("rst_state", state_dbg, 4'd0);
    chk("rst_outs", {mem_en, mem_rw, mem_clear, busy, frame_done, err_timeout}, 6'd0);
    chk("rst_fcnt", frame_count, '0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    mem_done = 1'b1; tick(); mem_done = 1'b0;
  endtask

  task automatic start_seq(input string tg);
    exp_cmd.push_back(2'b10);
    start = 1'b1; tick(); start = 1'b0;
    chk({tg, "_issue_clr"}, state_dbg, 4'd1);
    wait_state(4'd2, 5, {tg, "_wait_clr"});
    repeat (3) tick();
    pulse_done();
  endtask

  task automatic to_wait_rd(input string tg);
    wait_state(4'd3, 20, {tg, "_arm"});
    exp_cmd.push_back(2'b01);
    cam_frame_start = 1'b1; tick(); cam_frame_start = 1'b0;
    chk({tg, "_cap_lat"}, {mem_en, state_dbg}, {1'b1, 4'd4});
    wait_state(4'd5, 5, {tg, "_wait_wr"});
    tick();
    exp_cmd.push_back(2'b00);
    gray_ready = 1'b1;
    pulse_done();
    chk({tg, "_wait_gray"}, state_dbg, 4'd6);
    tick();
    chk({tg, "_issue_rd"}, {mem_en, state_dbg}, {1'b1, 4'd7});
    tick();
    chk({tg, "_wait_rd"}, state_dbg, 4'd8);
  endtask

  task automatic finish_read(input string tg, input logic cont);
    continuous = cont;
    exp_fc = exp_fc + 1'b1;
    exp_frm.push_back(exp_fc);
`ifdef FB_AUTO_CLEAR_EN
    if (cont) exp_cmd.push_back(2'b10);
`endif
    tick();
    pulse_done();
    chk({tg, "_fcnt"}, frame_count, exp_fc);
    if (!cont) begin
      chk({tg, "_idle"}, {busy, state_dbg}, {1'b0, 4'd0});
    end else begin
`ifdef FB_AUTO_CLEAR_EN
      wait_state(4'd2, 5, {tg, "_reclear"});
      repeat (2) tick();
      pulse_done();
`endif
      chk({tg, "_loop_arm"}, state_dbg, 4'd3);
    end
  endtask

  initial begin
    int en0;
    int cyc;

    // Test 1: single frame
    do_reset();
    n_en = 0; n_clr = 0;
    start_seq("t1");
    to_wait_rd("t1");
    finish_read("t1", 1'b0);
    chk("t1_n_en", n_en, 3);

    // Test 2: three continuous frames
    do_reset();
    n_en = 0; n_clr = 0;
    start_seq("t2");
    for (int f = 0; f < 3; f++) begin
      to_wait_rd("t2");
      finish_read("t2", (f < 2) ? 1'b1 : 1'b0);
    end
    chk("t2_n_clr", n_clr, EXP_CLR_T2);
    chk("t2_fcnt3", frame_count, 2'd3);

    // Test 3: watchdog expiry in WAIT_WR
    start_seq("t3");
    wait_state(4'd3, 20, "t3_arm");
    exp_cmd.push_back(2'b01);
    cam_frame_start = 1'b1; tick(); cam_frame_start = 1'b0;
    tick();
    cyc = 0;
    while (state_dbg == 4'd5 && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("t3_wd_cycles", cyc, 16);
    chk("t3_err_idle", {err_timeout, state_dbg}, {1'b1, 4'd0});
    chk("t3_fcnt", frame_count, exp_fc);
    exp_cmd.push_back(2'b10);
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_err_clr", err_timeout, 1'b0);
    wait_state(4'd2, 5, "t3_wait_clr");
    pulse_done();
    chk("t3_arm2", state_dbg, 4'd3);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_abort_arm", state_dbg, 4'd0);

    // Test 4: abort during WAIT_WR drains
    start_seq("t4");
    wait_state(4'd3, 20, "t4_arm");
    exp_cmd.push_back(2'b01);
    cam_frame_start = 1'b1; tick(); cam_frame_start = 1'b0;
    wait_state(4'd5, 5, "t4_wait_wr");
    repeat (3) tick();
    en0 = n_en;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_drain", state_dbg, 4'd9);
    repeat (9) tick();
    chk("t4_still_drain", state_dbg, 4'd9);
    pulse_done();
    chk("t4_idle", {busy, state_dbg}, {1'b0, 4'd0});
    chk("t4_no_en", n_en, en0);

    // Test 5: abort together with read completion
    start_seq("t5");
    to_wait_rd("t5");
    tick();
    abort = 1'b1; mem_done = 1'b1; tick(); abort = 1'b0; mem_done = 1'b0;
    chk("t5_idle", state_dbg, 4'd0);
    chk("t5_no_fd", frame_done, 1'b0);
    chk("t5_fcnt", frame_count, exp_fc);

    // Test 6: ignored frame-start, late grayscaler, counter wrap
    gray_ready = 1'b0;
    exp_cmd.push_back(2'b10);
    start = 1'b1; tick(); start = 1'b0;
    wait_state(4'd2, 5, "t6_wait_clr");
    cam_frame_start = 1'b1; tick(); cam_frame_start = 1'b0;
    repeat (2) tick();
    pulse_done();
    en0 = n_en;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("t6_arm_hold", state_dbg, 4'd3);
    chk("t6_no_wr", n_en, en0);
    exp_cmd.push_back(2'b01);
    cam_frame_start = 1'b1; tick(); cam_frame_start = 1'b0;
    wait_state(4'd5, 5, "t6_wait_wr");
    pulse_done();
    cyc = 0;
    while (state_dbg == 4'd6 && cyc < 50) begin
      cyc++;
      tick();
    end
    chk("t6_gray_wait", {state_dbg, cyc[7:0]}, {4'd6, 8'd50});
    exp_cmd.push_back(2'b00);
    gray_ready = 1'b1; tick();
    chk("t6_rd_lat", {mem_en, state_dbg}, {1'b1, 4'd7});
    tick();
    finish_read("t6", 1'b0);
    chk("t6_wrap", frame_count, 2'd0);

    tick(); tick();
    chk("end_cmd_q", exp_cmd.size(), 0);
    chk("end_frm_q", exp_frm.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
